// File: rtl/div_if.sv
// div_if: start/done handshake bundle between the execute-stage controller
// and the iterative divider. The controller side uses the master modport,
// the divider uses the slave modport.
interface div_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic             Signed;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic [WIDTH-1:0] Quotient;
   logic [WIDTH-1:0] Remainder;
   logic [3:0]       ALUFlags;
   logic             DivZero;
   logic             Busy;
   logic             Done;

   modport master (
      output Start, Signed, SrcA, SrcB,
      input  Quotient, Remainder, ALUFlags, DivZero, Busy, Done
   );

   modport slave (
      input  Start, Signed, SrcA, SrcB,
      output Quotient, Remainder, ALUFlags, DivZero, Busy, Done
   );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider (UDIV/SDIV).
// One quotient bit per cycle in RUN, sign fix-up in FIX, and the visible
// results plus the one-cycle Done pulse are registered on the edge that
// leaves DONE. A zero divisor skips straight from IDLE to DONE.
// Optional feature macro: DIV_SIGNED_EN (signed operation). When it is not
// defined the Signed input is ignored and every operation is unsigned.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic  clk,
   input  logic  reset,
   div_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   p_q, p_d;        // partial remainder, then final remainder
   logic [WIDTH-1:0] q_q, q_d;        // dividend shifting out / quotient shifting in
   logic [WIDTH-1:0] dvs_q, dvs_d;    // divisor magnitude
   logic             dz_q, dz_d;      // current operation had a zero divisor
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic [3:0]       flags_q, flags_d;
   logic             divzero_q, divzero_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef DIV_SIGNED_EN
   logic             qneg_q, qneg_d;  // quotient must be negated in FIX
   logic             rneg_q, rneg_d;  // remainder must be negated in FIX
`else
   logic             unused_signed;
   assign unused_signed = bus.Signed;
`endif

   // Working values for one restoring step and operand magnitudes.
   logic [WIDTH:0]   p_sh;
   logic [WIDTH-1:0] q_sh;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign bus.Quotient  = quotient_q;
   assign bus.Remainder = remainder_q;
   assign bus.ALUFlags  = flags_q;
   assign bus.DivZero   = divzero_q;
   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;

   // Next-state and datapath logic for the whole divider.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      p_d         = p_q;
      q_d         = q_q;
      dvs_d       = dvs_q;
      dz_d        = dz_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      flags_d     = flags_q;
      divzero_d   = divzero_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_d      = qneg_q;
      rneg_d      = rneg_q;
      a_mag = (bus.Signed && bus.SrcA[WIDTH-1]) ? -bus.SrcA : bus.SrcA;
      b_mag = (bus.Signed && bus.SrcB[WIDTH-1]) ? -bus.SrcB : bus.SrcB;
`else
      a_mag = bus.SrcA;
      b_mag = bus.SrcB;
`endif
      p_sh = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
      q_sh = {q_q[WIDTH-2:0], 1'b0};

      case (state_q)
         S_IDLE: begin
            // Busy falls here after the Done cycle unless a new request arrives.
            busy_d = 1'b0;
            if (bus.Start) begin
               busy_d    = 1'b1;
               divzero_d = 1'b0;
               cnt_d     = '0;
               dvs_d     = b_mag;
`ifdef DIV_SIGNED_EN
               qneg_d    = bus.Signed & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
               rneg_d    = bus.Signed & bus.SrcA[WIDTH-1];
`endif
               if (bus.SrcB == '0) begin
                  // Zero divisor: quotient 0, remainder is the raw dividend.
                  q_d     = '0;
                  p_d     = {1'b0, bus.SrcA};
                  dz_d    = 1'b1;
                  state_d = S_DONE;
               end else begin
                  q_d     = a_mag;
                  p_d     = '0;
                  dz_d    = 1'b0;
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (p_sh >= {1'b0, dvs_q}) begin
               p_d = p_sh - {1'b0, dvs_q};
               q_d = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
               p_d = p_sh;
               q_d = q_sh;
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
         end
         S_FIX: begin
`ifdef DIV_SIGNED_EN
            if (qneg_q) q_d = -q_q;
            if (rneg_q) p_d = {1'b0, -p_q[WIDTH-1:0]};
`endif
            state_d = S_DONE;
         end
         default: begin
            // S_DONE: publish results with the completion pulse.
            quotient_d  = q_q;
            remainder_d = p_q[WIDTH-1:0];
            flags_d     = {q_q[WIDTH-1], (q_q == '0), 2'b00};
            divzero_d   = dz_q;
            done_d      = 1'b1;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         p_q         <= '0;
         q_q         <= '0;
         dvs_q       <= '0;
         dz_q        <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         flags_q     <= '0;
         divzero_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
         qneg_q      <= 1'b0;
         rneg_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         p_q         <= p_d;
         q_q         <= q_d;
         dvs_q       <= dvs_d;
         dz_q        <= dz_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         flags_q     <= flags_d;
         divzero_q   <= divzero_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef DIV_SIGNED_EN
         qneg_q      <= qneg_d;
         rneg_q      <= rneg_d;
`endif
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_div_unit;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   int   lat;
   int   busy_cnt;
   logic dz0;

   div_if #(.WIDTH(32)) u_if ();

   div_unit #(.WIDTH(32)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; the next rising edge is edge 0.
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
      u_if.Start  = 1'b1;
      u_if.SrcA   = a;
      u_if.SrcB   = b;
      u_if.Signed = s;
      @(negedge clk);
      u_if.Start  = 1'b0;
   endtask

   // Called in the cycle after edge 0; returns in the Done cycle (or on timeout).
   // lat = number of edges after edge 0 until Done is seen.
   task automatic wait_done(input int inject_at, output int l, output int bc, output logic dz);
      int n;
      n  = 0;
      bc = 0;
      dz = u_if.DivZero;
      while (u_if.Done !== 1'b1 && n < 200) begin
         if (u_if.Busy === 1'b1) bc++;
         if (n == inject_at) begin
            u_if.Start = 1'b1;
            u_if.SrcA  = 32'd50;
            u_if.SrcB  = 32'd5;
         end else begin
            u_if.Start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      u_if.Start = 1'b0;
      l = n;
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      reset       = 1'b1;
      u_if.Start  = 1'b0;
      u_if.Signed = 1'b0;
      u_if.SrcA   = '0;
      u_if.SrcB   = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_quot", u_if.Quotient, 32'h0);
      check("rst_rem", u_if.Remainder, 32'h0);
      check("rst_flags", 32'(u_if.ALUFlags), 32'h0);
      check("rst_dz", 32'(u_if.DivZero), 32'h0);
      check("rst_busy", 32'(u_if.Busy), 32'h0);
      check("rst_done", 32'(u_if.Done), 32'h0);
      reset = 1'b0;

      // 100 / 7 unsigned
      @(negedge clk);
      launch(32'd100, 32'd7, 1'b0);
      wait_done(-1, lat, busy_cnt, dz0);
      check("u100_7_lat", 32'(lat), 32'd34);
      check("u100_7_busy_cnt", 32'(busy_cnt), 32'd34);
      check("u100_7_busy_done", 32'(u_if.Busy), 32'd1);
      check("u100_7_quot", u_if.Quotient, 32'd14);
      check("u100_7_rem", u_if.Remainder, 32'd2);
      check("u100_7_flags", 32'(u_if.ALUFlags), 32'h0);
      check("u100_7_dz", 32'(u_if.DivZero), 32'h0);
      @(negedge clk);
      check("u100_7_done_pulse", 32'(u_if.Done), 32'd0);
      check("u100_7_busy_after", 32'(u_if.Busy), 32'd0);
      check("u100_7_quot_hold", u_if.Quotient, 32'd14);

      // -100 / 7 with Signed = 1
      @(negedge clk);
      launch(32'hFFFF_FF9C, 32'd7, 1'b1);
      wait_done(-1, lat, busy_cnt, dz0);
      check("s_m100_7_lat", 32'(lat), 32'd34);
`ifdef DIV_SIGNED_EN
      check("s_m100_7_quot", u_if.Quotient, 32'hFFFF_FFF2);
      check("s_m100_7_rem", u_if.Remainder, 32'hFFFF_FFFE);
      check("s_m100_7_flags", 32'(u_if.ALUFlags), 32'h8);
`else
      check("s_m100_7_quot", u_if.Quotient, 32'h2492_4916);
      check("s_m100_7_rem", u_if.Remainder, 32'h0000_0002);
      check("s_m100_7_flags", 32'(u_if.ALUFlags), 32'h0);
`endif

      // Divide by zero
      @(negedge clk);
      launch(32'h1234_5678, 32'h0, 1'b0);
      wait_done(-1, lat, busy_cnt, dz0);
      check("dz_lat", 32'(lat), 32'd1);
      check("dz_flag", 32'(u_if.DivZero), 32'd1);
      check("dz_quot", u_if.Quotient, 32'h0);
      check("dz_rem", u_if.Remainder, 32'h1234_5678);
      check("dz_flags", 32'(u_if.ALUFlags), 32'h4);

      // 0x80000000 / 0xFFFFFFFF signed; accept also clears DivZero
      @(negedge clk);
      launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_done(-1, lat, busy_cnt, dz0);
      check("ovf_dz_cleared", 32'(dz0), 32'd0);
      check("ovf_lat", 32'(lat), 32'd34);
      check("ovf_dz", 32'(u_if.DivZero), 32'd0);
`ifdef DIV_SIGNED_EN
      check("ovf_quot", u_if.Quotient, 32'h8000_0000);
      check("ovf_rem", u_if.Remainder, 32'h0);
      check("ovf_flags", 32'(u_if.ALUFlags), 32'h8);
`else
      check("ovf_quot", u_if.Quotient, 32'h0);
      check("ovf_rem", u_if.Remainder, 32'h8000_0000);
      check("ovf_flags", 32'(u_if.ALUFlags), 32'h4);
`endif

      // 10 / 3 with an ignored Start 50 / 5 at cycle 5
      @(negedge clk);
      launch(32'd10, 32'd3, 1'b0);
      wait_done(5, lat, busy_cnt, dz0);
      check("ign_lat", 32'(lat), 32'd34);
      check("ign_quot", u_if.Quotient, 32'd3);
      check("ign_rem", u_if.Remainder, 32'd1);
      @(negedge clk);
      check("ign_no_second", 32'(u_if.Busy), 32'd0);

      // 9 / 2 aborted by reset at cycle 20
      @(negedge clk);
      launch(32'd9, 32'd2, 1'b0);
      repeat (20) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_done", 32'(u_if.Done), 32'd0);
      check("abort_busy", 32'(u_if.Busy), 32'd0);
      check("abort_quot", u_if.Quotient, 32'h0);
      check("abort_rem", u_if.Remainder, 32'h0);
      check("abort_flags", 32'(u_if.ALUFlags), 32'h0);
      check("abort_dz", 32'(u_if.DivZero), 32'd0);
      reset = 1'b0;
      // Divider is idle right away: a zero-divisor request completes in one cycle.
      launch(32'd7, 32'd0, 1'b0);
      wait_done(-1, lat, busy_cnt, dz0);
      check("post_abort_lat", 32'(lat), 32'd1);
      check("post_abort_quot", u_if.Quotient, 32'h0);
      check("post_abort_rem", u_if.Remainder, 32'd7);
      check("post_abort_dz", 32'(u_if.DivZero), 32'd1);

      // Back-to-back: second Start raised in the Done cycle of the first
      @(negedge clk);
      launch(32'hFFFF_FFFF, 32'd1, 1'b0);
      wait_done(-1, lat, busy_cnt, dz0);
      check("b2b1_lat", 32'(lat), 32'd34);
      check("b2b1_quot", u_if.Quotient, 32'hFFFF_FFFF);
      check("b2b1_rem", u_if.Remainder, 32'h0);
      check("b2b1_flags", 32'(u_if.ALUFlags), 32'h8);
      launch(32'd1, 32'hFFFF_FFFF, 1'b0);
      wait_done(-1, lat, busy_cnt, dz0);
      check("b2b2_lat", 32'(lat), 32'd34);
      check("b2b2_busy_cnt", 32'(busy_cnt), 32'd34);
      check("b2b2_quot", u_if.Quotient, 32'h0);
      check("b2b2_rem", u_if.Remainder, 32'd1);
      check("b2b2_flags", 32'(u_if.ALUFlags), 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
